// File: rtl/fullchip_seq_if.sv
// Host-side Q/K streaming handshake for the attention sequencer.
// The host drives in_valid; the sequencer answers with in_ready.
interface fullchip_seq_if;
  logic in_valid;
  logic in_ready;

  modport master (
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/fullchip_seq.sv
// Attention-run sequencer: streams Q/K, loads K, executes, drains, normalises.
// Command outputs are registered one cycle behind the state that issues them.
module fullchip_seq #(
  parameter int TOTAL_CYCLE = 8,
  parameter int COL         = 8,
  parameter int AW          = 4,
  parameter int GAP_CYC     = 10,
  parameter int DRAIN_CYC   = 8,
  parameter int NWAIT_CYC   = 4,
  parameter int IW          = 2*AW+9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              hsk_comp,
  fullchip_seq_if.slave     bus,
  output logic [IW-1:0]     inst,
  output logic              div,
  output logic              mac_array_clk_en,
  output logic              sfp_row_clk_en,
  output logic              kmem_clk_en,
  output logic              qmem_clk_en,
  output logic              busy,
  output logic              done
);

  if (TOTAL_CYCLE < 1) begin : g_chk_tc_min
    $error("TOTAL_CYCLE must be at least 1");
  end
  if (TOTAL_CYCLE + 2 > 2**AW) begin : g_chk_tc_max
    $error("TOTAL_CYCLE+2 must not exceed 2**AW");
  end
  if (COL < 1) begin : g_chk_col_min
    $error("COL must be at least 1");
  end
  if (COL + 1 > 2**AW) begin : g_chk_col_max
    $error("COL+1 must not exceed 2**AW");
  end
  if (GAP_CYC < 1 || GAP_CYC > 2**AW) begin : g_chk_gap
    $error("GAP_CYC must be in 1..2**AW");
  end
  if (DRAIN_CYC < 1 || DRAIN_CYC > 2**AW) begin : g_chk_drain
    $error("DRAIN_CYC must be in 1..2**AW");
  end
  if (NWAIT_CYC < 1 || NWAIT_CYC > 2**AW) begin : g_chk_nwait
    $error("NWAIT_CYC must be in 1..2**AW");
  end
  if (IW != 2*AW+9) begin : g_chk_iw
    $error("IW must equal 2*AW+9");
  end

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_QWR    = 4'd1;
  localparam logic [3:0] S_KWR    = 4'd2;
  localparam logic [3:0] S_KLOAD  = 4'd3;
  localparam logic [3:0] S_LDRAIN = 4'd4;
  localparam logic [3:0] S_GAP    = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_XDRAIN = 4'd7;
  localparam logic [3:0] S_OFIFO  = 4'd8;
  localparam logic [3:0] S_NWAIT  = 4'd9;
  localparam logic [3:0] S_NORM   = 4'd10;
  localparam logic [3:0] S_DONE   = 4'd11;

  localparam logic [AW-1:0] L_ONE    = AW'(1);
  localparam logic [AW-1:0] L_QLAST  = AW'(TOTAL_CYCLE-1);
  localparam logic [AW-1:0] L_KLAST  = AW'(COL-1);
  localparam logic [AW-1:0] L_LDLAST = AW'(COL);
  localparam logic [AW-1:0] L_GLAST  = AW'(GAP_CYC-1);
  localparam logic [AW-1:0] L_XLAST  = AW'(TOTAL_CYCLE+1);
  localparam logic [AW-1:0] L_DLAST  = AW'(DRAIN_CYC-1);
  localparam logic [AW-1:0] L_WLAST  = AW'(NWAIT_CYC-1);

  logic [3:0]    r_state;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] r_padd;
  logic          r_even;
  logic          r_in_ready;

  logic [IW-1:0] r_inst;
  logic          r_div;
  logic          r_mac_en;
  logic          r_sfp_en;
  logic          r_kmem_en;
  logic          r_qmem_en;
  logic          r_busy;
  logic          r_done;

  logic [3:0]    w_state_nxt;
  logic [AW-1:0] w_cnt_nxt;
  logic [AW-1:0] w_padd_nxt;
  logic          w_even_nxt;
  logic          w_acc;
  logic [AW-1:0] w_cnt_inc;

  logic          w_ofr;
  logic [AW-1:0] w_qadd;
  logic [AW-1:0] w_padd_o;
  logic          w_exe;
  logic          w_ld;
  logic          w_qrd;
  logic          w_qwr;
  logic          w_krd;
  logic          w_kwr;
  logic          w_pwr;
  logic          w_div;
  logic          w_mac;
  logic          w_sfp;
  logic          w_ken;
  logic          w_qen;
  logic          w_done;
  logic          w_ready_nxt;

  assign w_acc     = bus.in_valid & r_in_ready;
  assign w_cnt_inc = r_cnt + L_ONE;

  // Next-state, counter update and per-state command decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_padd_nxt  = r_padd;
    w_even_nxt  = r_even;
    w_ofr       = 1'b0;
    w_qadd      = '0;
    w_padd_o    = '0;
    w_exe       = 1'b0;
    w_ld        = 1'b0;
    w_qrd       = 1'b0;
    w_qwr       = 1'b0;
    w_krd       = 1'b0;
    w_kwr       = 1'b0;
    w_pwr       = 1'b0;
    w_div       = 1'b0;
    w_mac       = 1'b0;
    w_sfp       = 1'b0;
    w_ken       = 1'b0;
    w_qen       = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_QWR;
          w_cnt_nxt   = '0;
        end
      end
      S_QWR: begin
        w_qen  = 1'b1;
        w_qwr  = w_acc;
        w_qadd = r_cnt;
        if (w_acc) begin
          if (r_cnt == L_QLAST) begin
            w_state_nxt = S_KWR;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
      S_KWR: begin
        w_ken  = 1'b1;
        w_kwr  = w_acc;
        w_qadd = r_cnt;
        if (w_acc) begin
          if (r_cnt == L_KLAST) begin
            w_state_nxt = S_KLOAD;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
      S_KLOAD: begin
        w_ld   = 1'b1;
        w_ken  = 1'b1;
        w_krd  = (r_cnt != '0);
        w_qadd = (r_cnt == '0) ? '0 : r_cnt - L_ONE;
        if (r_cnt == L_LDLAST) begin
          w_state_nxt = S_LDRAIN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_LDRAIN: begin
        w_ld        = 1'b1;
        w_state_nxt = S_GAP;
        w_cnt_nxt   = '0;
      end
      S_GAP: begin
        w_mac = 1'b1;
        if (r_cnt == L_GLAST) begin
          w_state_nxt = S_EXEC;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_EXEC: begin
        w_mac  = 1'b1;
        w_exe  = 1'b1;
        w_qrd  = 1'b1;
        w_qen  = 1'b1;
        w_qadd = r_cnt;
        if (r_cnt == L_XLAST) begin
          w_state_nxt = S_XDRAIN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_XDRAIN: begin
        w_mac = 1'b1;
        if (r_cnt == L_DLAST) begin
          w_state_nxt = S_OFIFO;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_OFIFO: begin
        w_sfp = 1'b1;
        w_ofr = 1'b1;
        if (r_cnt == L_QLAST) begin
          w_state_nxt = S_NWAIT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_NWAIT: begin
        w_sfp = 1'b1;
        if (r_cnt == L_WLAST) begin
          w_state_nxt = S_NORM;
          w_cnt_nxt   = '0;
          w_padd_nxt  = '0;
          w_even_nxt  = 1'b0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_NORM: begin
        w_sfp    = 1'b1;
        w_padd_o = r_padd;
        if (!r_even) begin
          w_div      = 1'b1;
          w_pwr      = 1'b1;
          w_even_nxt = 1'b1;
        end else if (hsk_comp) begin
          w_pwr      = 1'b1;
          w_even_nxt = 1'b0;
          if (r_padd == L_QLAST) begin
            w_state_nxt = S_DONE;
            w_padd_nxt  = '0;
          end else begin
            w_padd_nxt = r_padd + L_ONE;
          end
        end
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_padd_nxt  = '0;
        w_even_nxt  = 1'b0;
      end
    endcase
  end

  // in_ready follows the next state so it lines up with the beat counter.
  assign w_ready_nxt = (w_state_nxt == S_QWR) || (w_state_nxt == S_KWR);

  // Sequencer state and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_padd     <= '0;
      r_even     <= 1'b0;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_padd     <= w_padd_nxt;
      r_even     <= w_even_nxt;
      r_in_ready <= w_ready_nxt;
    end
  end

  // Registered instruction word, divider flag, clock gates and status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inst    <= '0;
      r_div     <= 1'b0;
      r_mac_en  <= 1'b0;
      r_sfp_en  <= 1'b0;
      r_kmem_en <= 1'b0;
      r_qmem_en <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_inst    <= {w_ofr, w_qadd, w_padd_o, w_exe, w_ld,
                    w_qrd, w_qwr, w_krd, w_kwr, 1'b0, w_pwr};
      r_div     <= w_div;
      r_mac_en  <= w_mac;
      r_sfp_en  <= w_sfp;
      r_kmem_en <= w_ken;
      r_qmem_en <= w_qen;
      r_busy    <= (r_state != S_IDLE);
      r_done    <= w_done;
    end
  end

  assign bus.in_ready      = r_in_ready;
  assign inst              = r_inst;
  assign div               = r_div;
  assign mac_array_clk_en  = r_mac_en;
  assign sfp_row_clk_en    = r_sfp_en;
  assign kmem_clk_en       = r_kmem_en;
  assign qmem_clk_en       = r_qmem_en;
  assign busy              = r_busy;
  assign done              = r_done;

endmodule

// File: tb/tb_fullchip_seq.sv
// Bench for fullchip_seq: per-cycle schedule built from the phase rules,
// randomized handshakes/stalls, mid-run reset and a TOTAL_CYCLE=14 instance.
module tb_fullchip_seq;
  localparam int AW  = 4;
  localparam int IW  = 2*AW+9;
  localparam int TC  = 8;
  localparam int COL = 8;
  localparam int GAP = 10;
  localparam int DRN = 8;
  localparam int NW  = 4;
  localparam int W   = IW+7;
  localparam int TC2 = 14;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          start, hsk_comp;
  logic [IW-1:0] inst;
  logic          div, mac_en, sfp_en, ken, qen, busy, done;
  fullchip_seq_if bus();

  logic          start14;
  logic          hsk14;
  logic [IW-1:0] inst14;
  logic          div14, mac14, sfp14, ken14, qen14, busy14, done14;
  fullchip_seq_if bus14();

  fullchip_seq #(.TOTAL_CYCLE(TC), .COL(COL), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .hsk_comp(hsk_comp),
    .bus(bus), .inst(inst), .div(div),
    .mac_array_clk_en(mac_en), .sfp_row_clk_en(sfp_en),
    .kmem_clk_en(ken), .qmem_clk_en(qen),
    .busy(busy), .done(done)
  );

  fullchip_seq #(.TOTAL_CYCLE(TC2), .COL(COL), .AW(AW)) dut14 (
    .clk(clk), .reset(reset), .start(start14), .hsk_comp(hsk14),
    .bus(bus14), .inst(inst14), .div(div14),
    .mac_array_clk_en(mac14), .sfp_row_clk_en(sfp14),
    .kmem_clk_en(ken14), .qmem_clk_en(qen14),
    .busy(busy14), .done(done14)
  );

  logic [W-1:0] obs;
  assign obs = {inst, div, mac_en, sfp_en, ken, qen, busy, done};

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit ofr; int qa; int pa;
    bit exe, ld, qrd, qwr, krd, kwr, pwr;
    bit dv, mac, sfp, ken, qen, bsy, dn;
  } e_t;

  logic [W-1:0] q_word[$];
  bit q_rdy[$], q_v[$], q_h[$], q_s[$];
  int gq[TC];
  int gk[COL];
  int st[TC];

  function automatic logic [W-1:0] pack_e(e_t e);
    logic [AW-1:0] q, p;
    q = e.qa[AW-1:0];
    p = e.pa[AW-1:0];
    return {e.ofr, q, p, e.exe, e.ld, e.qrd, e.qwr, e.krd, e.kwr,
            1'b0, e.pwr, e.dv, e.mac, e.sfp, e.ken, e.qen, e.bsy, e.dn};
  endfunction

  function automatic e_t blank(bit bsy);
    e_t e;
    e = '{default: 0};
    e.bsy = bsy;
    return e;
  endfunction

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  task automatic push(e_t e, bit rdy, bit v, bit h, bit s);
    q_word.push_back(pack_e(e));
    q_rdy.push_back(rdy);
    q_v.push_back(v);
    q_h.push_back(h);
    q_s.push_back(s);
  endtask

  task automatic plan_zero();
    for (int i = 0; i < TC; i++) begin gq[i] = 0; st[i] = 0; end
    for (int i = 0; i < COL; i++) gk[i] = 0;
  endtask

  // Expected per-cycle outputs of one run, one entry per sequencer cycle.
  task automatic build();
    e_t e;
    q_word.delete(); q_rdy.delete(); q_v.delete();
    q_h.delete(); q_s.delete();
    for (int i = 0; i < TC; i++) begin
      e = blank(1); e.qen = 1; e.qa = i;
      for (int g = 0; g < gq[i]; g++) push(e, 1, 0, rb(), rb());
      e.qwr = 1; push(e, 1, 1, rb(), rb());
    end
    for (int i = 0; i < COL; i++) begin
      e = blank(1); e.ken = 1; e.qa = i;
      for (int g = 0; g < gk[i]; g++) push(e, 1, 0, rb(), rb());
      e.kwr = 1; push(e, 1, 1, rb(), rb());
    end
    for (int c = 0; c <= COL; c++) begin
      e = blank(1); e.ld = 1; e.ken = 1;
      e.krd = (c >= 1); e.qa = (c == 0) ? 0 : c - 1;
      push(e, 0, rb(), rb(), rb());
    end
    e = blank(1); e.ld = 1; push(e, 0, rb(), rb(), rb());
    for (int i = 0; i < GAP; i++) begin
      e = blank(1); e.mac = 1; push(e, 0, rb(), rb(), rb());
    end
    for (int i = 0; i < TC + 2; i++) begin
      e = blank(1); e.mac = 1; e.exe = 1; e.qrd = 1; e.qen = 1; e.qa = i;
      push(e, 0, rb(), rb(), rb());
    end
    for (int i = 0; i < DRN; i++) begin
      e = blank(1); e.mac = 1; push(e, 0, rb(), rb(), rb());
    end
    for (int i = 0; i < TC; i++) begin
      e = blank(1); e.sfp = 1; e.ofr = 1; push(e, 0, rb(), rb(), rb());
    end
    for (int i = 0; i < NW; i++) begin
      e = blank(1); e.sfp = 1; push(e, 0, rb(), rb(), rb());
    end
    for (int j = 0; j < TC; j++) begin
      e = blank(1); e.sfp = 1; e.pa = j; e.dv = 1; e.pwr = 1;
      push(e, 0, rb(), rb(), rb());
      e = blank(1); e.sfp = 1; e.pa = j;
      for (int g = 0; g < st[j]; g++) push(e, 0, rb(), 0, rb());
      e.pwr = 1; push(e, 0, rb(), 1, rb());
    end
    e = blank(1); e.dn = 1; push(e, 0, rb(), rb(), rb());
    e = blank(0); push(e, 0, rb(), rb(), 0);
  endtask

  task automatic run_sched(input string nm, output int done_at);
    int n;
    n = q_word.size();
    done_at = -1;
    start = 1; bus.in_valid = rb(); hsk_comp = rb();
    @(posedge clk); #1;
    for (int k = 0; k < n; k++) begin
      start = q_s[k]; bus.in_valid = q_v[k]; hsk_comp = q_h[k];
      @(negedge clk);
      checks++;
      if (bus.in_ready !== q_rdy[k]) begin
        errors++;
        $display("FAIL %s rdy[%0d] got %b exp %b", nm, k, bus.in_ready, q_rdy[k]);
      end
      if (k > 0) begin
        checks++;
        if (obs !== q_word[k-1]) begin
          errors++;
          $display("FAIL %s out[%0d] got %h exp %h", nm, k, obs, q_word[k-1]);
        end
      end
      if (done === 1'b1 && done_at < 0) done_at = k;
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (obs !== q_word[n-1]) begin
      errors++;
      $display("FAIL %s out[%0d] got %h exp %h", nm, n, obs, q_word[n-1]);
    end
    start = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1; start = 1; bus.in_valid = 1; hsk_comp = 1;
    start14 = 0; bus14.in_valid = 1; hsk14 = 1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs !== '0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got %h/%b exp 0/0", obs, bus.in_ready);
    end
    reset = 0; start = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset busy=%b rdy=%b exp 0/0", busy, bus.in_ready);
    end
  endtask

  task automatic test_nominal();
    int d;
    plan_zero();
    build();
    for (int k = 0; k < q_v.size(); k++) begin
      q_v[k] = 1; q_h[k] = 1;
    end
    run_sched("nominal", d);
    checks++;
    if (d !== 83) begin
      errors++;
      $display("FAIL nominal_latency got %0d exp 83", d);
    end
  endtask

  task automatic test_valid_gap();
    int d;
    plan_zero();
    gq[4] = 3;
    build();
    run_sched("valid_gap", d);
    checks++;
    if (d !== 86) begin
      errors++;
      $display("FAIL valid_gap_latency got %0d exp 86", d);
    end
  endtask

  task automatic test_hsk_stall();
    int d;
    plan_zero();
    st[1] = 5;
    build();
    run_sched("hsk_stall", d);
    checks++;
    if (d !== 88) begin
      errors++;
      $display("FAIL hsk_stall_latency got %0d exp 88", d);
    end
  endtask

  task automatic test_random();
    int d;
    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < TC; i++) begin
        gq[i] = $urandom_range(0, 2);
        st[i] = $urandom_range(0, 3);
      end
      for (int i = 0; i < COL; i++) gk[i] = $urandom_range(0, 2);
      build();
      run_sched("random", d);
      checks++;
      if (d !== q_word.size() - 1) begin
        errors++;
        $display("FAIL random_latency got %0d exp %0d", d, q_word.size() - 1);
      end
    end
  endtask

  task automatic test_midrun_reset();
    int d;
    start = 1; bus.in_valid = 1; hsk_comp = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (41) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (inst[7] !== 1'b1) begin
      errors++;
      $display("FAIL midrun_in_exec execute got %b exp 1", inst[7]);
    end
    #2 reset = 1;
    #1;
    checks++;
    if (obs !== '0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrun_async_reset got %h/%b exp 0/0", obs, bus.in_ready);
    end
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk); #1;
    plan_zero();
    build();
    run_sched("restart", d);
    checks++;
    if (d !== q_word.size() - 1) begin
      errors++;
      $display("FAIL restart_latency got %0d exp %0d", d, q_word.size() - 1);
    end
  endtask

  task automatic test_tc14();
    int adds[$];
    bit seen;
    seen = 0;
    start14 = 1;
    @(posedge clk); #1;
    start14 = 0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      if (inst14[7] === 1'b1) adds.push_back(int'(inst14[8+AW +: AW]));
      if (done14 === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL tc14_done got timeout exp done");
    end
    checks++;
    if (adds.size() != TC2 + 2) begin
      errors++;
      $display("FAIL tc14_exec_len got %0d exp %0d", adds.size(), TC2 + 2);
    end
    for (int i = 0; i < adds.size(); i++) begin
      checks++;
      if (adds[i] != i) begin
        errors++;
        $display("FAIL tc14_exec_add[%0d] got %0d exp %0d", i, adds[i], i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_valid_gap();
    test_hsk_stall();
    test_random();
    test_midrun_reset();
    test_tc14();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
